// File: rtl/modadd_stream_if.sv
// Stream handshake bundle for modadd_stream: operand side (A, B, qH) and
// result side (C), each with its own valid/ready pair.
interface modadd_stream_if #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47
);
  logic             in_valid;
  logic             in_ready;
  logic [LOGQ-1:0]  A;
  logic [LOGQ-1:0]  B;
  logic [LOGQH-1:0] qH;
  logic             out_valid;
  logic             out_ready;
  logic [LOGQ-1:0]  C;

  // Producer/consumer side: drives operands, consumes results
  modport master (
    output in_valid, A, B, qH, out_ready,
    input  in_ready, out_valid, C
  );

  // Adder side
  modport slave (
    input  in_valid, A, B, qH, out_ready,
    output in_ready, out_valid, C
  );
endinterface

// File: rtl/modadd_stream.sv
// modadd_stream: three-stage pipelined modular adder, C = (A + B) mod q with
// q = {qH, zeros, 1}. qH travels with each beat.
// Build option MODADD_STREAM_BUBBLE_COLLAPSE_EN: when defined, each stage
// advances independently so bubbles are squeezed out under backpressure;
// when undefined, the whole pipeline stalls while the result is held.
module modadd_stream #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47
) (
  input  logic          clk,
  input  logic          rst,
  modadd_stream_if.slave io
);

  // Stage 1: operands and modulus high part
  logic             v1;
  logic [LOGQ-1:0]  a1;
  logic [LOGQ-1:0]  b1;
  logic [LOGQH-1:0] qh1;

  // Stage 2: raw sum and sum minus modulus (sign bit on top)
  logic             v2;
  logic [LOGQ:0]    s2;
  logic [LOGQ+1:0]  d2;

  // Stage 3: reduced result
  logic             v3;
  logic [LOGQ-1:0]  c3;

  // Per-stage load enables
  logic en1;
  logic en2;
  logic en3;

  logic [LOGQ-1:0] q1;
  logic [LOGQ:0]   s_n;
  logic [LOGQ+1:0] d_n;
  logic [LOGQ-1:0] c_n;

  // Stage load enables for the selected stall policy
`ifdef MODADD_STREAM_BUBBLE_COLLAPSE_EN
  always_comb begin
    en3 = !v3 || io.out_ready;
    en2 = !v2 || en3;
    en1 = !v1 || en2;
  end
`else
  always_comb begin
    en3 = !(v3 && !io.out_ready);
    en2 = en3;
    en1 = en3;
  end
`endif

  assign io.in_ready  = en1 && !rst;
  assign io.out_valid = v3;
  assign io.C         = c3;

  // Arithmetic between stages: modulus assembly, sum, trial subtraction, select
  always_comb begin
    q1  = {qh1, {(LOGQ-LOGQH-1){1'b0}}, 1'b1};
    s_n = {1'b0, a1} + {1'b0, b1};
    d_n = {1'b0, s_n} - {2'b00, q1};
    // A negative difference means the sum was already below q
    c_n = LOGQ'(d2[LOGQ+1] ? s2 : d2[LOGQ:0]);
  end

  // Stage 1 register: capture a beat when the handshake completes
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      qh1 <= '0;
    end else if (en1) begin
      v1  <= io.in_valid && io.in_ready;
      a1  <= io.A;
      b1  <= io.B;
      qh1 <= io.qH;
    end
  end

  // Stage 2 register: sum and sum minus q
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
      d2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      s2 <= s_n;
      d2 <= d_n;
    end
  end

  // Stage 3 register: reduced result, held while downstream is not ready
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      c3 <= '0;
    end else if (en3) begin
      v3 <= v2;
      c3 <= c_n;
    end
  end

endmodule

// File: tb/tb_modadd_stream.sv
// Directed bench for modadd_stream: basic sum, wrap/equal boundaries,
// backpressure, bubbles, mid-stream reset and a randomized stream.
module tb_modadd_stream;

  logic clk;
  logic rst;

  modadd_stream_if #(.LOGQ(64), .LOGQH(47)) io ();

  modadd_stream #(.LOGQ(64), .LOGQH(47)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [46:0] QH0 = 47'h400008C00000;
  localparam logic [63:0] QM1 = 64'h8000118000000000;

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  bit          lat_mode = 1'b0;
  logic        fired;
  logic [63:0] exp_c[$];
  int          exp_t[$];
  logic [63:0] held;
  int          nacc;
  logic [63:0] ra, rb, rq;
  logic [46:0] rqh;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [46:0] qh);
    logic [127:0] q;
    logic [127:0] s;
    q = {64'd0, qh, 16'd0, 1'b1};
    s = {64'd0, a} + {64'd0, b};
    return 64'(s % q);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score handshakes at the falling edge, then advance
  task automatic cyc();
    logic [63:0] e;
    int t;
    @(negedge clk);
    if (io.out_valid && io.out_ready) begin
      checks++;
      assert (exp_c.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result: observed %h, expected none", io.C);
      end
      if (exp_c.size() != 0) begin
        e = exp_c.pop_front();
        t = exp_t.pop_front();
        chk("result", io.C, e);
        if (lat_mode) chk("latency", 64'(cycle - t), 64'd3);
      end
    end
    fired = io.in_valid && io.in_ready;
    if (fired) begin
      exp_c.push_back(model(io.A, io.B, io.qH));
      exp_t.push_back(cycle);
    end
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic new_rand_beat();
    rqh = 47'({$urandom(), $urandom()});
    rq  = {rqh, 16'd0, 1'b1};
    ra  = {$urandom(), $urandom()} % rq;
    rb  = {$urandom(), $urandom()} % rq;
    if ($urandom_range(0, 7) == 0) ra = rq - 64'd1;
    if ($urandom_range(0, 7) == 0) rb = rq - 64'd1;
  endtask

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.A = '0;
    io.B = '0;
    io.qH = QH0;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready", 64'(io.in_ready), 64'd0);
    cyc();
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_c", io.C, 64'd0);
    chk("rst_in_ready_2", 64'(io.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(io.in_ready), 64'd1);

    // Basic sum, latency 3
    lat_mode = 1'b1;
    io.A = 64'h010000000000000A;
    io.B = 64'h1000000000000005;
    io.in_valid = 1'b1;
    cyc();
    chk("basic_accept", 64'(fired), 64'd1);
    io.in_valid = 1'b0;
    cyc();
    chk("basic_not_early", 64'(io.out_valid), 64'd0);
    cyc();
    chk("basic_out_valid", 64'(io.out_valid), 64'd1);
    chk("basic_c", io.C, 64'h110000000000000F);
    cyc();

    // Wrap/equal boundaries, back-to-back
    io.in_valid = 1'b1;
    io.A = QM1; io.B = 64'd1; cyc();
    io.A = QM1; io.B = 64'd2; cyc();
    io.A = QM1; io.B = QM1;   cyc();
    io.in_valid = 1'b0;
    chk("wrap_eq_c", io.C, 64'd0);
    cyc();
    chk("wrap_one_c", io.C, 64'd1);
    cyc();
    chk("wrap_carry_c", io.C, 64'h8000117FFFFFFFFF);
    cyc();

    // Backpressure: 8 beats, out_ready low for 5 cycles mid-stream
    lat_mode = 1'b0;
    nacc = 0;
    for (int k = 0; k < 30 && (nacc < 8 || exp_c.size() != 0); k++) begin
      io.out_ready = !(k >= 6 && k < 11);
      io.in_valid  = (nacc < 8);
      io.A = 64'h7000000000000000 + 64'(nacc);
      io.B = 64'h1000118000000000 + 64'(nacc);
      #1;
      if (k == 6) held = io.C;
      if (k >= 6 && k < 11) chk("bp_in_ready", 64'(io.in_ready), 64'd0);
      if (k >= 7 && k < 11) begin
        chk("bp_c_held", io.C, held);
        chk("bp_out_valid", 64'(io.out_valid), 64'd1);
      end
      cyc();
      if (fired) nacc++;
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    chk("bp_count", 64'(nacc), 64'd8);
    chk("bp_drained", 64'(exp_c.size()), 64'd0);

    // Bubbles under downstream stall
    io.out_ready = 1'b0;
    io.A = 64'h0000000000001234; io.B = 64'h0000000000004321;
    io.in_valid = 1'b1; #1;
    chk("bub_in_ready_0", 64'(io.in_ready), 64'd1);
    cyc();
    io.in_valid = 1'b0; #1;
    chk("bub_in_ready_1", 64'(io.in_ready), 64'd1);
    cyc();
    io.A = QM1; io.B = 64'd5;
    io.in_valid = 1'b1; #1;
    chk("bub_in_ready_2", 64'(io.in_ready), 64'd1);
    cyc();
    io.in_valid = 1'b0; #1;
`ifdef MODADD_STREAM_BUBBLE_COLLAPSE_EN
    chk("bub_in_ready_3", 64'(io.in_ready), 64'd1);
`else
    chk("bub_in_ready_3", 64'(io.in_ready), 64'd0);
`endif
    cyc();
    io.out_ready = 1'b1;
    chk("bub_first_valid", 64'(io.out_valid), 64'd1);
    chk("bub_first_c", io.C, 64'h0000000000005555);
    cyc();
`ifdef MODADD_STREAM_BUBBLE_COLLAPSE_EN
    chk("bub_second_valid", 64'(io.out_valid), 64'd1);
`else
    chk("bub_second_valid", 64'(io.out_valid), 64'd0);
`endif
    for (int k = 0; k < 4; k++) cyc();
    chk("bub_drained", 64'(exp_c.size()), 64'd0);

    // Reset with three beats in flight
    io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      io.A = 64'd100 + 64'(k); io.B = 64'd7;
      cyc();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(io.in_ready), 64'd0);
    cyc();
    chk("mid_rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("mid_rst_c", io.C, 64'd0);
    chk("mid_rst_in_ready_2", 64'(io.in_ready), 64'd0);
    exp_c.delete();
    exp_t.delete();
    rst = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    #1;
    chk("mid_rst_release_ready", 64'(io.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_ghost", 64'(io.out_valid), 64'd0);
      cyc();
    end
    lat_mode = 1'b1;
    io.A = QM1; io.B = QM1; io.in_valid = 1'b1;
    cyc();
    io.in_valid = 1'b0;
    cyc(); cyc();
    chk("after_rst_valid", 64'(io.out_valid), 64'd1);
    chk("after_rst_c", io.C, 64'h8000117FFFFFFFFF);
    cyc();

    // Random stream with random valid/ready
    lat_mode = 1'b0;
    nacc = 0;
    new_rand_beat();
    for (int k = 0; k < 20000 && nacc < 2000; k++) begin
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.out_ready = ($urandom_range(0, 3) != 0);
      io.A = ra; io.B = rb; io.qH = rqh;
      cyc();
      if (fired) begin
        nacc++;
        new_rand_beat();
      end
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("rand_count", 64'(nacc), 64'd2000);
    chk("rand_drained", 64'(exp_c.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
